// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared geometry constants and scan state type for the display scanner
package disp_pkg;
    localparam int ROWS   = 32;
    localparam int COLS   = 32;
    localparam int ADDR_W = 10;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} scan_state_t;
endpackage

// File: rtl/disp_scan_timing.sv
// rtl/disp_scan_timing.sv - raster counters, scan FSM, memory address and unaligned pixel tags
module disp_scan_timing
    import disp_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int HB_SLOTS = 4,
    parameter int VB_LINES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              raw_valid,
    output logic [ROW_W-1:0]  raw_row,
    output logic [COL_W-1:0]  raw_col,
    output logic              raw_line_start,
    output logic              raw_frame_start,
    output logic              frame_done,
    output logic              busy
);
    localparam int SLOTS  = COLS + HB_SLOTS;
    localparam int LINES  = ROWS + VB_LINES;
    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int SLOT_W = $clog2(SLOTS + 1);
    localparam int LINE_W = $clog2(LINES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] COL_LAST  = SLOT_W'(COLS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [LINE_W-1:0] ROW_LAST  = LINE_W'(ROWS - 1);

    scan_state_t       state;
    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic              div_wrap;
    logic              slot_wrap;
    logic              line_wrap;

    assign div_wrap  = div_cnt == DIV_LAST;
    assign slot_wrap = div_wrap && (slot_cnt == SLOT_LAST);
    assign line_wrap = slot_wrap && (line_cnt == LINE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            slot_cnt  <= '0;
            line_cnt  <= '0;
            addr_hold <= '0;
        end else begin
            addr_hold <= mem_addr;
            // Counters wrap to zero on the last clock of a frame, so IDLE always restarts at (0,0)
            if (state != IDLE) begin
                div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
                if (div_wrap)
                    slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
                if (slot_wrap)
                    line_cnt <= line_wrap ? '0 : line_cnt + 1'b1;
            end
            case (state)
                IDLE:    if (en) state <= ACTIVE;
                ACTIVE:  if (div_wrap && (slot_cnt == COL_LAST)) state <= HBLANK;
                HBLANK:  if (slot_wrap) begin
                    if (line_cnt != ROW_LAST)
                        state <= ACTIVE;
                    else if (VB_LINES > 0)
                        state <= VBLANK;
                    else
                        state <= en ? ACTIVE : IDLE;
                end
                VBLANK:  if (line_wrap) state <= en ? ACTIVE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy            = state != IDLE;
    assign raw_valid       = state == ACTIVE;
    assign raw_row         = line_cnt[ROW_W-1:0];
    assign raw_col         = slot_cnt[COL_W-1:0];
    assign raw_line_start  = raw_valid && (slot_cnt == '0) && (div_cnt == '0);
    assign raw_frame_start = raw_line_start && (line_cnt == '0);
    assign frame_done      = busy && line_wrap;
    // Address parks on the last visible pixel during blanking and idle
    assign mem_addr        = raw_valid ? {raw_row, raw_col} : addr_hold;
endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - raster scanner top: timing core plus two-stage tag alignment to memory data
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIV    = 2,
    parameter int HBLANK = 4,
    parameter int VBLANK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_d,
    output logic              pix_o,
    output logic              pix_valid,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic              line_start,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);
    logic             raw_valid;
    logic [ROW_W-1:0] raw_row;
    logic [COL_W-1:0] raw_col;
    logic             raw_line_start;
    logic             raw_frame_start;

    logic             s1_valid;
    logic [ROW_W-1:0] s1_row;
    logic [COL_W-1:0] s1_col;
    logic             s1_line_start;
    logic             s1_frame_start;

    disp_scan_timing #(
        .DIV      (DIV),
        .HB_SLOTS (HBLANK),
        .VB_LINES (VBLANK)
    ) u_timing (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .mem_addr        (mem_addr),
        .raw_valid       (raw_valid),
        .raw_row         (raw_row),
        .raw_col         (raw_col),
        .raw_line_start  (raw_line_start),
        .raw_frame_start (raw_frame_start),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    // Stage 1 tracks the memory's read register; stage 2 lands alongside the sampled mem_d
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s1_row         <= '0;
            s1_col         <= '0;
            s1_line_start  <= 1'b0;
            s1_frame_start <= 1'b0;
            pix_valid      <= 1'b0;
            pix_o          <= 1'b0;
            row_o          <= '0;
            col_o          <= '0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            s1_valid       <= raw_valid;
            s1_row         <= raw_valid ? raw_row : '0;
            s1_col         <= raw_valid ? raw_col : '0;
            s1_line_start  <= raw_line_start;
            s1_frame_start <= raw_frame_start;
            pix_valid      <= s1_valid;
            pix_o          <= s1_valid & mem_d;
            row_o          <= s1_row;
            col_o          <= s1_col;
            line_start     <= s1_line_start;
            frame_start    <= s1_frame_start;
        end
    end
endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - self-checking bench for disp_scan with an arithmetic raster reference model
module tb_disp_scan;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en_a, en_b;
    logic [9:0] addr_a, addr_b;
    logic       d_a, d_b;
    logic       pix_a, val_a, ls_a, fs_a, fd_a, busy_a;
    logic       pix_b, val_b, ls_b, fs_b, fd_b, busy_b;
    logic [4:0] row_a, col_a, row_b, col_b;

    bit mem_a [1024];
    bit mem_b [1024];

    always @(posedge clk) begin
        d_a <= mem_a[addr_a];
        d_b <= mem_b[addr_b];
    end

    disp_scan #(.DIV(2), .HBLANK(4), .VBLANK(2)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .mem_addr(addr_a), .mem_d(d_a),
        .pix_o(pix_a), .pix_valid(val_a), .row_o(row_a), .col_o(col_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_done(fd_a), .busy(busy_a)
    );

    disp_scan #(.DIV(1), .HBLANK(1), .VBLANK(0)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .mem_addr(addr_b), .mem_d(d_b),
        .pix_o(pix_b), .pix_valid(val_b), .row_o(row_b), .col_o(col_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_done(fd_b), .busy(busy_b)
    );

    int         sel;
    logic [9:0] o_addr;
    logic [4:0] o_row, o_col;
    logic       o_pix, o_val, o_ls, o_fs, o_fd, o_busy;

    always_comb begin
        if (sel == 0) begin
            o_addr = addr_a; o_row = row_a; o_col = col_a; o_pix = pix_a; o_val = val_a;
            o_ls = ls_a; o_fs = fs_a; o_fd = fd_a; o_busy = busy_a;
        end else begin
            o_addr = addr_b; o_row = row_b; o_col = col_b; o_pix = pix_b; o_val = val_b;
            o_ls = ls_b; o_fs = fs_b; o_fd = fd_b; o_busy = busy_b;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int exp_hold [2];

    typedef struct {
        bit v;
        int row;
        int col;
        bit ls;
        bit fs;
        int addr;
    } tag_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit mem_rd(input int s, input int a);
        return (s == 0) ? mem_a[a] : mem_b[a];
    endfunction

    task automatic set_en(input int s, input logic v);
        if (s == 0) en_a = v;
        else        en_b = v;
    endtask

    task automatic chk_quiet(input int s, input int exp_addr);
        sel = s;
        #1;
        chk("q_busy", o_busy, 0);
        chk("q_pix_valid", o_val, 0);
        chk("q_pix_o", o_pix, 0);
        chk("q_row", o_row, 0);
        chk("q_col", o_col, 0);
        chk("q_line_start", o_ls, 0);
        chk("q_frame_start", o_fs, 0);
        chk("q_frame_done", o_fd, 0);
        chk("q_mem_addr", o_addr, exp_addr);
    endtask

    // Starts a scan from IDLE, drops en after cycle drop_c, and checks every clock
    // against position arithmetic until the pipeline has drained into IDLE.
    task automatic run_scan(input int s, input int div, input int hb, input int vb, input int drop_c);
        int   slots, flen, c, end_c, k, slot, line, col;
        int   nval, nfd, ones, exp_ones, nframes;
        bit   en_now;
        tag_t q[$];
        tag_t cur, old;
        slots = 32 + hb;
        flen  = (32 + vb) * slots * div;
        end_c = 1 << 30;
        nval = 0; nfd = 0; ones = 0; exp_ones = 0; nframes = 0;
        cur = '{default: 0};
        q = {};
        q.push_back(cur);
        q.push_back(cur);
        sel = s;
        @(negedge clk);
        set_en(s, 1'b1);
        en_now = 1'b1;
        c = 0;
        while (c < end_c + 3 && c < drop_c + 2 * flen + 16) begin
            @(negedge clk);
            k = c % flen;
            cur = '{default: 0};
            if (c < end_c) begin
                slot = k / div;
                line = slot / slots;
                col  = slot % slots;
                cur.v = (line < 32) && (col < 32);
                if (cur.v) begin
                    cur.row  = line;
                    cur.col  = col;
                    cur.ls   = (col == 0) && (k % div == 0);
                    cur.fs   = cur.ls && (line == 0);
                    cur.addr = line * 32 + col;
                    exp_hold[s] = cur.addr;
                end
                if (k == 0) nframes++;
                chk("busy", o_busy, 1);
                chk("frame_done", o_fd, k == flen - 1);
            end else begin
                chk("busy_idle", o_busy, 0);
                chk("frame_done_idle", o_fd, 0);
            end
            chk("mem_addr", o_addr, exp_hold[s]);
            old = q.pop_front();
            q.push_back(cur);
            chk("pix_valid", o_val, old.v);
            chk("line_start", o_ls, old.ls);
            chk("frame_start", o_fs, old.fs);
            if (old.v) begin
                chk("row_o", o_row, old.row);
                chk("col_o", o_col, old.col);
                chk("pix_o", o_pix, mem_rd(s, old.addr));
                if (mem_rd(s, old.addr)) exp_ones++;
            end
            if (o_val) nval++;
            if (o_fd) nfd++;
            if (o_val && o_pix) ones++;
            if (c == drop_c) begin
                set_en(s, 1'b0);
                en_now = 1'b0;
            end
            if (c < end_c && k == flen - 1 && !en_now) end_c = c + 1;
            c++;
        end
        set_en(s, 1'b0);
        chk("valid_count", nval, nframes * 1024 * div);
        chk("frame_done_count", nfd, nframes);
        chk("ones_count", ones, exp_ones);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        sel = 0;
        exp_hold[0] = 0;
        exp_hold[1] = 0;
        repeat (3) @(negedge clk);
        chk_quiet(0, 0);
        chk_quiet(1, 0);
        reset = 1'b0;
        @(negedge clk);
        chk_quiet(0, 0);

        // Checkerboard, two back-to-back frames, en dropped at row 10 of the second
        for (int i = 0; i < 1024; i++) mem_a[i] = bit'(i[0] ^ i[5]);
        run_scan(0, 2, 4, 2, 2448 + 10 * 36 * 2);
        chk_quiet(0, 1023);

        for (int i = 0; i < 1024; i++) mem_a[i] = bit'($urandom_range(0, 1));
        run_scan(0, 2, 4, 2, 0);

        // Single lit pixel in the corner, no vertical blanking
        for (int i = 0; i < 1024; i++) mem_b[i] = 1'b0;
        mem_b[1023] = 1'b1;
        run_scan(1, 1, 1, 0, 1056 + 100);
        chk_quiet(1, 1023);

        for (int i = 0; i < 1024; i++) mem_b[i] = bit'($urandom_range(0, 1));
        run_scan(1, 1, 1, 0, 0);

        // Reset mid-frame at row 5 col 7, then a clean restart
        sel = 0;
        @(negedge clk);
        en_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (val_a && row_a == 5'd5 && col_a == 5'd7) found = 1'b1;
        end
        chk("reached_r5c7", found, 1);
        reset = 1'b1;
        en_a = 1'b0;
        @(negedge clk);
        chk_quiet(0, 0);
        reset = 1'b0;
        exp_hold[0] = 0;
        for (int i = 0; i < 1024; i++) mem_a[i] = bit'($urandom_range(0, 1));
        run_scan(0, 2, 4, 2, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/disp_scan.md
Name: disp_scan

Overview:
- Raster scanner sitting directly downstream of the 1-bit x 1024 display memory (mem_disp).
- Walks the 32x32 bitmap row-major, drives the memory read address and absorbs the memory's 1-cycle registered read latency.
- Emits an aligned pixel stream with row/col tags, line/frame markers and horizontal/vertical blanking for the display driver.
- Read-only: the write port of the memory belongs to the upstream drawing logic.

Parameters:
- DIV, 2, clocks per pixel slot (>=1)
- HBLANK, 4, blank pixel slots appended after each row (>=1)
- VBLANK, 2, blank lines after row 31, each COLS+HBLANK slots (>=0)
- ROWS, 32, display rows (fixed; ROWS*COLS = 1024)
- COLS, 32, display columns (fixed)

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- en  in  1  scan enable
- mem_addr  out  10  read address to memory, {row[4:0], col[4:0]}
- mem_d  in  1  memory read data (valid 1 clk after mem_addr)
- pix_o  out  1  pixel value
- pix_valid  out  1  pix_o/row_o/col_o valid this cycle
- row_o  out  5  row of pix_o
- col_o  out  5  column of pix_o
- line_start  out  1  1-clk pulse with first pixel (col 0) of each row
- frame_start  out  1  1-clk pulse with pixel (0,0)
- frame_done  out  1  1-clk pulse on last clk of final VBLANK slot
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock port is clk; reset is synchronous, active-high; one clock domain.
- Reset: state IDLE; all counters 0; mem_addr 0; pix_o, pix_valid, row_o, col_o, line_start, frame_start, frame_done, busy all 0. Reset mid-frame aborts immediately: outputs are 0 after the edge, and in-flight read data is discarded.
- Counters: div_cnt 0..DIV-1; slot_cnt 0..COLS+HBLANK-1; line_cnt 0..ROWS+VBLANK-1. slot_cnt advances when div_cnt wraps; line_cnt advances when slot_cnt wraps.
- mem_addr = {line_cnt[4:0], slot_cnt[4:0]} from registered counters, presented only when slot_cnt<COLS and line_cnt<ROWS. Otherwise hold last value.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE -> ACTIVE when en=1; counters start at 0.
  - ACTIVE -> HBLANK when slot_cnt wraps past COLS-1.
  - HBLANK -> ACTIVE at the next row; HBLANK -> VBLANK after row ROWS-1.
  - VBLANK -> ACTIVE at the next frame if en=1, else -> IDLE.
  - If VBLANK=0: HBLANK of row 31 goes directly to ACTIVE or IDLE.
- en is sampled only in IDLE and at the frame boundary. Deasserting en mid-frame completes the current frame.
- Latency: a two-stage tag pipeline (valid, row, col, line/frame flags) aligns with memory data. Cycle t: address issued. t+1: mem_d valid. t+2: pix_o <= mem_d registered, tags aligned. Fixed 2-clk latency from address to pix_o.
- pix_valid is high for all DIV clocks of each active slot: 1024*DIV valid clocks per frame, none during blanking.
- line_start/frame_start are high on the first clk of the first slot only.
- frame_done is not delayed; it fires on the last VBLANK clk, or on the last HBLANK clk of row 31 when VBLANK=0.
- Frame length = (ROWS+VBLANK)*(COLS+HBLANK)*DIV clocks; defaults give 2448.
- Back-to-back frames: no idle clocks between frame_done and the next address 0.
- Row wrap: col 31 -> HBLANK -> col 0 of row+1. Row 31 -> VBLANK -> row 0.

Decomposition:
- disp_pkg: ROWS, COLS, ADDR_W=10, ROW_W=5, COL_W=5, and typedef enum scan_state_t {IDLE, ACTIVE, HBLANK, VBLANK}.
- One sub-module: disp_scan_timing, which holds the counters and FSM and produces address and raw tags. The top adds the 2-stage align pipeline.

Test Plan:
- Preload mem with checkerboard (addr[0]^addr[5]), DIV=2, en=1 -> pix_o sequence 0,0,1,1,... on row 0. Row 1 starts with 1. pix_valid count = 2048 per frame.
- Preload a single 1 at addr 10'h3FF, DIV=1 -> pix_o=1 only when row_o=31, col_o=31. That occurs 2 clks after mem_addr=10'h3FF.
- Pulse timing, defaults -> frame_start 2 clks after leaving IDLE. line_start every 72 clks. frame_done period 2448 clks.
- Drop en at row 10 -> frame finishes, frame_done fires once, then busy=0 and mem_addr holds.
- Assert reset at row 5 col 7 -> next cycle pix_valid=0, busy=0, row_o=0. Restart with en gives frame_start at (0,0).
- VBLANK=0, HBLANK=1, DIV=1 -> frame = 32*33 = 1056 clks. frame_done is followed immediately by address 0 on the next clk.
